irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Machine-mode interrupt arbiter, directly downstream of clint.
- Consumes clint timer_irq_o / software_irq_o plus NUM_EXT external level lines.
- Owns mie/mip state (CSR 0x304/0x344) and picks the highest-priority enabled pending source.
- Issues a held trap request with mcause to the core pipeline over a req/ack handshake; blocks re-arbitration until mret.

Parameters:
NUM_EXT, 4, number of external interrupt lines (1..16), OR-reduced into MEIP
SYNC_STAGES, 2, synchronizer depth on ext_irq_i (used only with IRQ_SYNC_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
timer_irq_i  in  1  from clint timer_irq_o, level
software_irq_i  in  1  from clint software_irq_o, level
ext_irq_i  in  NUM_EXT  external level interrupts
mstatus_mie_i  in  1  global enable from core CSR file
csr_we  in  1  CSR write strobe, single cycle
csr_addr  in  12  CSR address
csr_wdata  in  32  CSR write data
csr_rdata  out  32  CSR read data, combinational
irq_req_o  out  1  trap request to core
irq_cause_o  out  32  mcause value, valid while irq_req_o
irq_ext_id_o  out  4  lowest-index active enabled ext line, valid with cause 11
irq_ack_i  in  1  core accepted trap, single cycle
mret_i  in  1  core retired mret, single cycle

Behaviour:
- Reset on the rst_n low edge sample: mie=0, mip=0, state=IDLE, irq_req_o=0, irq_cause_o=0, irq_ext_id_o=0. Synchronizer flops are cleared too.
- mip register:
  - Every cycle: MSIP(bit3)=software_irq_i, MTIP(bit7)=timer_irq_i, MEIP(bit11)=|ext_irq_i. Registered, so 1-cycle latency.
  - All other bits read 0.
  - Read-only: writes to 0x344 are ignored.
- mie register (0x304):
  - Writable bits 3, 7, 11 only; other bits read 0.
  - A write takes effect on the next edge.
- csr_rdata: mie for 0x304, mip for 0x344, 0 for any other address.
- Priority among (mip & mie): MEI(11) > MSI(3) > MTI(7).
- irq_cause_o = 0x8000_0000 | code.
- FSM:
  - IDLE: if mstatus_mie_i and (mip&mie)!=0, go to REQ. The cause/ext_id are latched and irq_req_o=1 on the same edge, so request latency from a source edge is 2 cycles.
  - REQ: hold irq_req_o, cause and ext_id stable. There is no re-arbitration even if a higher-priority source arrives or the original source drops.
    - On irq_ack_i: irq_req_o=0, go to SERVICE.
    - If mstatus_mie_i=0 and no ack: withdraw, irq_req_o=0, go to IDLE.
    - If ack and mstatus_mie_i=0 arrive together, the ack wins.
  - SERVICE: no requests. On mret_i go to IDLE; re-arbitration is possible on the following cycle.
  - irq_ack_i outside REQ and mret_i outside SERVICE are ignored.
- ext id: the lowest index i with ext_irq_i[i]=1 (post-sync), latched at IDLE->REQ. Zero-extended to 4 bits.
- Sources are level-only; this block does no clearing. The source (clint mtimecmp rewrite / msip write) clears the condition.
- A mie write on the same edge as the IDLE->REQ decision: the decision uses the old mie.
- rst_n low mid-REQ/SERVICE: back to reset values on that edge. No request survives.

Optional Feature:
IRQ_SYNC_EN
- Defined: ext_irq_i passes through SYNC_STAGES-flop synchronizers before MEIP/ext_id logic, adding SYNC_STAGES cycles of latency on external lines only. Timer/software inputs are unaffected (same clock domain as clint).
- Undefined: ext_irq_i is used directly; SYNC_STAGES is ignored.

Decomposition:
- Shared package irq_pkg holds:
  - CSR_MIE=12'h304, CSR_MIP=12'h344
  - bit indices MSI=3, MTI=7, MEI=11
  - CAUSE_INT=32'h8000_0000
  - state enum {IDLE, REQ, SERVICE}
- One natural sub-module, irq_sync: parameterised-depth, reset-clearing bit synchronizer. It is instantiated per ext line only when IRQ_SYNC_EN is defined.

Test Plan:
- Reset, then read 0x304/0x344 -> both 0x0000_0000; irq_req_o=0.
- Write mie=0x80, drive timer_irq_i=1 with mstatus_mie_i=1 -> irq_req_o high 2 cycles later, cause=0x8000_0007; hold 5 cycles without ack -> cause stable; ack -> req low; mret -> IDLE.
- mie=0x888; assert timer, software and ext_irq_i=4'b0110 on the same cycle -> cause=0x8000_000B, ext_id=1.
- In REQ (cause 7), raise software_irq_i -> cause stays 0x8000_0007 until ack. After ack and mret, with software still high -> new req, cause=0x8000_0003.
- In REQ, drop mstatus_mie_i -> irq_req_o low next edge, state IDLE; restore -> request reissued.
- Write 0x344=0xFFFF_FFFF and 0x304=0xFFFF_FFFF -> mip unchanged, mie reads 0x0000_0888. With IRQ_SYNC_EN, ext-to-req latency is 2+SYNC_STAGES cycles.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared definitions for the machine-mode interrupt arbiter:
//                CSR addresses, mip/mie bit positions, mcause interrupt flag,
//                arbiter state encoding and the fixed-priority cause picker.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // CSR addresses owned by the arbiter
    localparam logic [11:0] CSR_MIE = 12'h304;
    localparam logic [11:0] CSR_MIP = 12'h344;

    // Bit positions inside mie/mip (also the mcause exception codes)
    localparam int MSI = 3;
    localparam int MTI = 7;
    localparam int MEI = 11;

    // Interrupt flag of mcause
    localparam logic [31:0] CAUSE_INT = 32'h8000_0000;

    // Only the three implemented interrupt bits exist in mie/mip
    localparam logic [31:0] MIE_MASK  = 32'h0000_0888;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Fixed priority MEI > MSI > MTI. Returns 0 when nothing is pending;
    // callers only use the result when at least one bit is set.
    function automatic logic [3:0] pick_code(input logic [31:0] pend);
        logic [3:0] code;
        code = 4'd0;
        if (pend[MEI]) begin
            code = 4'(MEI);
        end else if (pend[MSI]) begin
            code = 4'(MSI);
        end else if (pend[MTI]) begin
            code = 4'(MTI);
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync
//  Description : Single-bit flop-chain synchronizer of configurable depth.
//                All stages clear on reset so no stale level survives it.
//  Parameters  : STAGES - number of flops in the chain (>= 1)
//  Ports       : clk   in  system clock
//                rst_n in  synchronous active-low reset
//                d     in  asynchronous level input
//                q     out synchronized level (STAGES cycles of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift towards the MSB; written as a shift so a single-stage chain
    // needs no special case.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
        end
    end

    assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter
//  Description : Machine-mode interrupt arbiter sitting behind the CLINT.
//                Holds mie (0x304) and mip (0x344), selects the highest
//                priority enabled pending source (MEI > MSI > MTI) and raises
//                a held trap request with mcause to the core. After the core
//                acknowledges, no new request is made until mret retires.
//  Build macro : IRQ_SYNC_EN - when defined, each ext_irq_i line passes
//                through a SYNC_STAGES-deep synchronizer before use.
//  Parameters  : NUM_EXT     - number of external lines (1..16)
//                SYNC_STAGES - synchronizer depth (IRQ_SYNC_EN only)
//  Ports       : clk            in  system clock
//                rst_n          in  synchronous active-low reset
//                timer_irq_i    in  CLINT timer level
//                software_irq_i in  CLINT software level
//                ext_irq_i      in  external levels, OR-reduced into MEIP
//                mstatus_mie_i  in  global interrupt enable
//                csr_we         in  CSR write strobe
//                csr_addr       in  CSR address
//                csr_wdata      in  CSR write data
//                csr_rdata      out CSR read data (combinational)
//                irq_req_o      out trap request
//                irq_cause_o    out mcause, valid while irq_req_o
//                irq_ext_id_o   out lowest active ext line, valid with cause 11
//                irq_ack_i      in  core accepted the trap
//                mret_i         in  core retired mret
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_EXT     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               timer_irq_i,
    input  logic               software_irq_i,
    input  logic [NUM_EXT-1:0] ext_irq_i,
    input  logic               mstatus_mie_i,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               irq_req_o,
    output logic [31:0]        irq_cause_o,
    output logic [3:0]         irq_ext_id_o,
    input  logic               irq_ack_i,
    input  logic               mret_i
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (NUM_EXT < 1 || NUM_EXT > 16 || SYNC_STAGES < 1) begin : g_bad_cfg
        $error("irq_arbiter: unsupported NUM_EXT or SYNC_STAGES");
    end

    // ------------------------------------------------------------------
    // External line conditioning
    // ------------------------------------------------------------------
    logic [NUM_EXT-1:0] ext_s;

`ifdef IRQ_SYNC_EN
    for (genvar g = 0; g < NUM_EXT; g++) begin : g_ext_sync
        irq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (ext_irq_i[g]),
            .q     (ext_s[g])
        );
    end
`else
    assign ext_s = ext_irq_i;
`endif

    // ------------------------------------------------------------------
    // CSR state
    // ------------------------------------------------------------------
    logic [31:0]        mie_q;
    logic [31:0]        mip_q;
    logic [31:0]        mip_next;
    // Snapshot of the ext lines taken on the same edge as MEIP, so the
    // reported ext id always belongs to the MEIP value that won arbitration.
    logic [NUM_EXT-1:0] ext_q;
    logic [3:0]         ext_lowest;
    logic [31:0]        pend;

    always_comb begin
        mip_next      = '0;
        mip_next[MSI] = software_irq_i;
        mip_next[MTI] = timer_irq_i;
        mip_next[MEI] = |ext_s;
    end

    // Lowest-index active line wins: scan from the top down so the last
    // hit is the smallest index.
    always_comb begin
        ext_lowest = '0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (ext_q[i]) begin
                ext_lowest = 4'(i);
            end
        end
    end

    // Registered mie is used, so a write landing on the arbitration edge
    // does not influence that decision.
    assign pend = mip_q & mie_q;

    always_comb begin
        unique case (csr_addr)
            CSR_MIE: csr_rdata = mie_q;
            CSR_MIP: csr_rdata = mip_q;
            default: csr_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    irq_state_t state;
    irq_state_t state_next;
    logic       load_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mstatus_mie_i && (pend != '0)) begin
                    state_next = REQ;
                    load_req   = 1'b1;
                end
            end
            REQ: begin
                // The ack has priority over a global-disable withdrawal:
                // once the core has taken the trap it must be serviced.
                if (irq_ack_i) begin
                    state_next = SERVICE;
                end else if (!mstatus_mie_i) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (mret_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [31:0] cause_q;
    logic [3:0]  ext_id_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mie_q    <= '0;
            mip_q    <= '0;
            ext_q    <= '0;
            cause_q  <= '0;
            ext_id_q <= '0;
        end else begin
            mip_q <= mip_next;
            ext_q <= ext_s;
            // mip is read-only; only mie accepts writes, masked to the
            // implemented bits.
            if (csr_we && (csr_addr == CSR_MIE)) begin
                mie_q <= csr_wdata & MIE_MASK;
            end
            // Cause and id are captured once and held for the whole
            // request; later source changes never re-arbitrate.
            if (load_req) begin
                cause_q  <= CAUSE_INT | 32'(pick_code(pend));
                ext_id_q <= ext_lowest;
            end
        end
    end

    assign irq_req_o    = (state == REQ);
    assign irq_cause_o  = cause_q;
    assign irq_ext_id_o = ext_id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_arbiter
//  Description : Scoreboard bench for irq_arbiter. A reference model advanced
//                once per clock pushes the expected request level and each
//                expected new trap (cause, ext id) into queues; a monitor on
//                the falling edge pops and compares. Directed scenarios are
//                followed by a randomized run. Honors IRQ_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

    localparam int NUM_EXT     = 4;
    localparam int SYNC_STAGES = 2;
`ifdef IRQ_SYNC_EN
    localparam int EXT_LAT = SYNC_STAGES;
`else
    localparam int EXT_LAT = 0;
`endif
    localparam logic [31:0] CINT = 32'h8000_0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               timer_irq_i;
    logic               software_irq_i;
    logic [NUM_EXT-1:0] ext_irq_i;
    logic               mstatus_mie_i;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata;
    logic [31:0]        csr_rdata;
    logic               irq_req_o;
    logic [31:0]        irq_cause_o;
    logic [3:0]         irq_ext_id_o;
    logic               irq_ack_i;
    logic               mret_i;

    always #5 clk = ~clk;

    irq_arbiter #(
        .NUM_EXT     (NUM_EXT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .timer_irq_i    (timer_irq_i),
        .software_irq_i (software_irq_i),
        .ext_irq_i      (ext_irq_i),
        .mstatus_mie_i  (mstatus_mie_i),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .irq_req_o      (irq_req_o),
        .irq_cause_o    (irq_cause_o),
        .irq_ext_id_o   (irq_ext_id_o),
        .irq_ack_i      (irq_ack_i),
        .mret_i         (mret_i)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] cause;
        logic [3:0]  ext_id;
    } req_t;

    req_t evt_q[$];
    bit   lvl_q[$];

    // Reference model: mie/mip as plain words, phase 0=waiting,
    // 1=requesting, 2=in handler.
    logic [31:0]        m_mie;
    logic [31:0]        m_mip;
    logic [NUM_EXT-1:0] m_ext;
    int                 m_phase;
`ifdef IRQ_SYNC_EN
    logic [NUM_EXT-1:0] hist[$];
`endif

    function automatic int top_code(input logic [31:0] pend);
        int order[3] = '{11, 3, 7};
        foreach (order[k]) begin
            if (pend[order[k]]) return order[k];
        end
        return 0;
    endfunction

    function automatic logic [3:0] lowest_ext(input logic [NUM_EXT-1:0] v);
        for (int i = 0; i < NUM_EXT; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        if (a == 12'h304) return m_mie;
        if (a == 12'h344) return m_mip;
        return 32'h0;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT saw.
    task automatic model_edge();
        logic [NUM_EXT-1:0] eff;
        logic [31:0]        pend;
        req_t               r;
        if (!rst_n) begin
            m_mie   = '0;
            m_mip   = '0;
            m_ext   = '0;
            m_phase = 0;
`ifdef IRQ_SYNC_EN
            hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) hist.push_back('0);
`endif
            lvl_q.push_back(1'b0);
            return;
        end
`ifdef IRQ_SYNC_EN
        eff = hist.pop_front();
        hist.push_back(ext_irq_i);
`else
        eff = ext_irq_i;
`endif
        pend = m_mip & m_mie;
        case (m_phase)
            0: if (mstatus_mie_i && pend != 0) begin
                r.cause  = CINT + 32'(top_code(pend));
                r.ext_id = lowest_ext(m_ext);
                evt_q.push_back(r);
                m_phase = 1;
            end
            1: if (irq_ack_i) m_phase = 2;
               else if (!mstatus_mie_i) m_phase = 0;
            default: if (mret_i) m_phase = 0;
        endcase
        if (csr_we && csr_addr == 12'h304) m_mie = csr_wdata & 32'h888;
        m_mip = (32'(software_irq_i) << 3) | (32'(timer_irq_i) << 7)
              | (32'(|eff) << 11);
        m_ext = eff;
        lvl_q.push_back(m_phase == 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic check_csr(input logic [11:0] a);
        csr_addr = a;
        #1;
        chk("csr_rdata", csr_rdata, model_rd(a));
    endtask

    task automatic ack_and_mret();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk("req_after_ack", 32'(irq_req_o), 32'd0);
        timer_irq_i    = 1'b0;
        software_irq_i = 1'b0;
        ext_irq_i      = '0;
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        cycles(2 + EXT_LAT);
    endtask

    // Monitor: one expected level per edge, one expected trap per new request
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        bit   exp_lvl;
        req_t e;
        if (lvl_q.size() > 0) begin
            exp_lvl = lvl_q.pop_front();
            compared++;
            if (irq_req_o !== exp_lvl) begin
                mismatched++;
                $display("FAIL req_level: got %b expected %b at %0t", irq_req_o, exp_lvl, $time);
            end
            if (irq_req_o === 1'b1 && !prev_req) begin
                compared++;
                if (evt_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_req: got cause 0x%08h expected no request at %0t",
                             irq_cause_o, $time);
                end else begin
                    e = evt_q.pop_front();
                    if (irq_cause_o !== e.cause) begin
                        mismatched++;
                        $display("FAIL req_cause: got 0x%08h expected 0x%08h at %0t",
                                 irq_cause_o, e.cause, $time);
                    end
                    if (e.cause == (CINT | 32'd11)) begin
                        compared++;
                        if (irq_ext_id_o !== e.ext_id) begin
                            mismatched++;
                            $display("FAIL req_ext_id: got %0d expected %0d at %0t",
                                     irq_ext_id_o, e.ext_id, $time);
                        end
                    end
                end
            end
            prev_req = (irq_req_o === 1'b1);
        end
    end

    initial begin
        logic [11:0] a;
        rst_n          = 1'b0;
        timer_irq_i    = 1'b0;
        software_irq_i = 1'b0;
        ext_irq_i      = '0;
        mstatus_mie_i  = 1'b0;
        csr_we         = 1'b0;
        csr_addr       = 12'h304;
        csr_wdata      = '0;
        irq_ack_i      = 1'b0;
        mret_i         = 1'b0;

        cycles(2);
        rst_n = 1'b1;
        csr_addr = 12'h304; #1; chk("reset_mie", csr_rdata, 32'h0);
        csr_addr = 12'h344; #1; chk("reset_mip", csr_rdata, 32'h0);
        chk("reset_req", 32'(irq_req_o), 32'd0);
        chk("reset_cause", irq_cause_o, 32'h0);

        // Timer only: 2-cycle latency, stable while held
        csr_write(12'h304, 32'h80);
        mstatus_mie_i = 1'b1;
        timer_irq_i   = 1'b1;
        tick();
        chk("timer_not_yet", 32'(irq_req_o), 32'd0);
        tick();
        chk("timer_req", 32'(irq_req_o), 32'd1);
        chk("timer_cause", irq_cause_o, 32'h8000_0007);
        cycles(5);
        chk("timer_hold_cause", irq_cause_o, 32'h8000_0007);
        ack_and_mret();
        chk("idle_after_mret", 32'(irq_req_o), 32'd0);

        // All three at once: external wins, lowest line reported
        csr_write(12'h304, 32'h888);
        ext_irq_i = 4'b0110;
        cycles(EXT_LAT);
        timer_irq_i    = 1'b1;
        software_irq_i = 1'b1;
        cycles(2);
        chk("all_cause", irq_cause_o, 32'h8000_000B);
        chk("all_ext_id", 32'(irq_ext_id_o), 32'd1);
        ack_and_mret();

        // External-only latency
        ext_irq_i = 4'b1000;
        cycles(1 + EXT_LAT);
        chk("ext_not_yet", 32'(irq_req_o), 32'd0);
        tick();
        chk("ext_req", 32'(irq_req_o), 32'd1);
        chk("ext_id3", 32'(irq_ext_id_o), 32'd3);
        ack_and_mret();

        // No re-arbitration while requesting
        csr_write(12'h304, 32'h88);
        timer_irq_i = 1'b1;
        cycles(2);
        software_irq_i = 1'b1;
        cycles(3);
        chk("hold_cause7", irq_cause_o, 32'h8000_0007);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        tick();
        chk("rearb_req", 32'(irq_req_o), 32'd1);
        chk("rearb_cause3", irq_cause_o, 32'h8000_0003);
        ack_and_mret();

        // Global disable withdraws, re-enable reissues
        timer_irq_i = 1'b1;
        cycles(2);
        mstatus_mie_i = 1'b0;
        tick();
        chk("withdraw", 32'(irq_req_o), 32'd0);
        mstatus_mie_i = 1'b1;
        tick();
        chk("reissue", 32'(irq_req_o), 32'd1);
        ack_and_mret();

        // mip is read-only, mie keeps only implemented bits
        csr_write(12'h344, 32'hFFFF_FFFF);
        csr_write(12'h304, 32'hFFFF_FFFF);
        csr_addr = 12'h304; #1; chk("mie_mask", csr_rdata, 32'h0000_0888);
        csr_addr = 12'h344; #1; chk("mip_ro", csr_rdata, 32'h0);
        check_csr(12'h123);

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            rst_n         = ($urandom_range(199) != 0);
            mstatus_mie_i = ($urandom_range(7) != 0);
            if ($urandom_range(5) == 0) timer_irq_i    = 1'($urandom);
            if ($urandom_range(5) == 0) software_irq_i = 1'($urandom);
            if ($urandom_range(5) == 0) ext_irq_i      = NUM_EXT'($urandom);
            irq_ack_i = ($urandom_range(2) == 0);
            mret_i    = ($urandom_range(3) == 0);
            case ($urandom_range(3))
                0:       a = 12'h304;
                1:       a = 12'h344;
                default: a = 12'($urandom);
            endcase
            check_csr(a);
            if ($urandom_range(4) == 0) begin
                csr_we    = 1'b1;
                csr_addr  = ($urandom_range(1) == 0) ? 12'h304 : 12'h344;
                csr_wdata = $urandom;
            end else begin
                csr_we = 1'b0;
            end
            tick();
        end

        csr_we = 1'b0; irq_ack_i = 1'b0; mret_i = 1'b0; rst_n = 1'b1;
        cycles(3);
        @(negedge clk);
        #1;
        chk("level_queue_drained", 32'(lvl_q.size()), 32'd0);
        chk("trap_queue_drained", 32'(evt_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
